// File: rtl/irq_encoder_if.sv
// Request/presentation bundle between the request collector and its consumer.
`timescale 1ns/1ps

interface irq_encoder_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       clr_ovf;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overflow;

    // Consumer side: raises requests, masks sources, acknowledges codes.
    modport master (
        output req, mask, ack, clr_ovf,
        input  code, valid, pending, overflow
    );

    // Encoder side.
    modport slave (
        input  req, mask, ack, clr_ovf,
        output code, valid, pending, overflow
    );
endinterface

// File: rtl/irq_encoder.sv
// Registered 8-to-3 priority encoder: sticky rising-edge pending register,
// masked priority selection and a valid/ack hold-until-accepted handshake.
`timescale 1ns/1ps

module irq_encoder #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_encoder_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] code_q;
    logic [2:0] code_next;
    logic [7:0] req_d;
    logic [7:0] pending_q;
    logic       ovf_q;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] clr;
    logic [2:0] winner;
    logic       ovf_evt;

    assign rise     = bus.req & ~req_d;
    assign eligible = pending_q & ~bus.mask;
    assign ovf_evt  = |(rise & pending_q & ~clr);

    // Pick the highest-priority eligible index according to LOW_FIRST.
    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (LOW_FIRST) begin
                if (eligible[7 - i]) winner = 3'(7 - i);
            end else begin
                if (eligible[i]) winner = 3'(i);
            end
        end
    end

    // Handshake FSM: load a winner when idle, hold it until acknowledged.
    always_comb begin
        state_next = state;
        code_next  = code_q;
        clr        = '0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    code_next  = winner;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ack) begin
                    clr[code_q] = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state and presented code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= '0;
        end else begin
            state  <= state_next;
            code_q <= code_next;
        end
    end

    // Edge history, sticky pending bits (rise beats clear) and overflow (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            req_d     <= bus.req;
            pending_q <= (pending_q & ~clr) | rise;
            if (ovf_evt)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign bus.code     = code_q;
    assign bus.valid    = (state == PRESENT);
    assign bus.pending  = pending_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Bench for irq_encoder: directed vector table, reset corner sequences and a
// randomized run against a reference model for both priority directions.
`timescale 1ns/1ps

module tb_irq_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irq_encoder_if bus_lo();
    irq_encoder_if bus_hi();

    irq_encoder #(.LOW_FIRST(1'b1)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(bus_lo.slave));
    irq_encoder #(.LOW_FIRST(1'b0)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(bus_hi.slave));

    assign bus_hi.req     = bus_lo.req;
    assign bus_hi.mask    = bus_lo.mask;
    assign bus_hi.ack     = bus_lo.ack;
    assign bus_hi.clr_ovf = bus_lo.clr_ovf;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic a, input logic c);
        bus_lo.req     = r;
        bus_lo.mask    = m;
        bus_lo.ack     = a;
        bus_lo.clr_ovf = c;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       clr_ovf;
        logic [2:0] code;
        logic       valid;
        logic [7:0] pending;
        logic       ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] r, input logic [7:0] m, input logic a, input logic c,
                       input logic [2:0] ec, input logic ev, input logic [7:0] ep, input logic eo);
        vec_t v;
        v.req = r; v.mask = m; v.ack = a; v.clr_ovf = c;
        v.code = ec; v.valid = ev; v.pending = ep; v.ovf = eo;
        vq.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_req_d [2];
    logic [7:0] m_pend  [2];
    logic [2:0] m_code  [2];
    bit         m_valid [2];
    bit         m_ovf   [2];

    function automatic int pick(input logic [7:0] elig, input bit low_first);
        if (low_first) begin
            for (int i = 0; i < 8; i++) if (elig[i]) return i;
        end else begin
            for (int i = 7; i >= 0; i--) if (elig[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_req_d[k] = '0; m_pend[k] = '0; m_code[k] = '0;
            m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    // Advance model k by one clock edge using the currently driven inputs.
    task automatic model_step(input int k, input bit low_first);
        logic [7:0] rise;
        logic [7:0] clr;
        bit evt;
        int w;
        rise = bus_lo.req & ~m_req_d[k];
        clr = '0;
        if (m_valid[k] && bus_lo.ack) clr[m_code[k]] = 1'b1;
        evt = 1'b0;
        for (int i = 0; i < 8; i++)
            if (rise[i] && m_pend[k][i] && !clr[i]) evt = 1'b1;
        w = pick(m_pend[k] & ~bus_lo.mask, low_first);
        if (!m_valid[k]) begin
            if (w >= 0) begin
                m_code[k]  = 3'(w);
                m_valid[k] = 1'b1;
            end
        end else if (bus_lo.ack) begin
            m_valid[k] = 1'b0;
        end
        for (int i = 0; i < 8; i++)
            m_pend[k][i] = rise[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pend[k][i]);
        if (evt) m_ovf[k] = 1'b1;
        else if (bus_lo.clr_ovf) m_ovf[k] = 1'b0;
        m_req_d[k] = bus_lo.req;
    endtask

    initial begin
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) step();
        check("reset code", 8'(bus_lo.code), 8'h00);
        check("reset valid", 8'(bus_lo.valid), 8'h00);
        check("reset pending", bus_lo.pending, 8'h00);
        check("reset overflow", 8'(bus_lo.overflow), 8'h00);
        rst_n = 1'b1;

        //   req    mask   ack   clr   code  valid pend   ovf
        // single request held without ack, then acked
        add(8'h08, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0);
        for (int i = 0; i < 5; i++)
            add(8'h00, 8'h00, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0);
        // two simultaneous rises: 0 then 7 with a gap cycle
        add(8'h81, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 8'h81, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'h81, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h80, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd7, 1'b1, 8'h80, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0);
        // masked source stays pending, presented after unmask
        add(8'h05, 8'h01, 1'b0, 1'b0, 3'd7, 1'b0, 8'h05, 1'b0);
        add(8'h00, 8'h01, 1'b0, 1'b0, 3'd2, 1'b1, 8'h05, 1'b0);
        add(8'h00, 8'h01, 1'b1, 1'b0, 3'd2, 1'b0, 8'h01, 1'b0);
        add(8'h00, 8'h01, 1'b0, 1'b0, 3'd2, 1'b0, 8'h01, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        // higher-priority arrival during presentation does not preempt
        add(8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0);
        add(8'h01, 8'h00, 1'b0, 1'b0, 3'd2, 1'b1, 8'h05, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 8'h01, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
        // overflow on a repeat rise, single ack, then clr_ovf
        add(8'h10, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h10, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0);
        add(8'h10, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 8'h00, 1'b1);
        add(8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0);
        // ack coinciding with a fresh rise on the presented bit, then idle ack
        add(8'h02, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 8'h02, 1'b0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'h02, 1'b0);
        add(8'h02, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 8'h02, 1'b0);
        add(8'h02, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'h02, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0);

        foreach (vq[i]) begin
            drive(vq[i].req, vq[i].mask, vq[i].ack, vq[i].clr_ovf);
            step();
            check($sformatf("vec%0d code", i), 8'(bus_lo.code), 8'(vq[i].code));
            check($sformatf("vec%0d valid", i), 8'(bus_lo.valid), 8'(vq[i].valid));
            check($sformatf("vec%0d pending", i), bus_lo.pending, vq[i].pending);
            check($sformatf("vec%0d overflow", i), 8'(bus_lo.overflow), 8'(vq[i].ovf));
        end

        // reset asserted mid-presentation with overflow set
        drive(8'h40, 8'h00, 1'b0, 1'b0); step();
        drive(8'h00, 8'h00, 1'b0, 1'b0); step();
        drive(8'h40, 8'h00, 1'b0, 1'b0); step();
        check("pre-reset valid", 8'(bus_lo.valid), 8'h01);
        check("pre-reset code", 8'(bus_lo.code), 8'h06);
        check("pre-reset overflow", 8'(bus_lo.overflow), 8'h01);
        drive(8'h20, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async reset code", 8'(bus_lo.code), 8'h00);
        check("async reset valid", 8'(bus_lo.valid), 8'h00);
        check("async reset pending", bus_lo.pending, 8'h00);
        check("async reset overflow", 8'(bus_lo.overflow), 8'h00);
        step();
        // req held high across reset release counts as a rise
        rst_n = 1'b1;
        step();
        check("release rise pending", bus_lo.pending, 8'h20);
        check("release rise valid", 8'(bus_lo.valid), 8'h00);
        step();
        check("release rise code", 8'(bus_lo.code), 8'h05);
        check("release rise present", 8'(bus_lo.valid), 8'h01);

        // randomized run against the model, both priority directions
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        model_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            logic [7:0] m;
            r = bus_lo.req ^ 8'($urandom & $urandom);
            m = bus_lo.mask;
            if ($urandom_range(0, 7) == 0) m = 8'($urandom & $urandom);
            drive(r, m, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            model_step(0, 1'b1);
            model_step(1, 1'b0);
            step();
            check("rnd lo code", 8'(bus_lo.code), 8'(m_code[0]));
            check("rnd lo valid", 8'(bus_lo.valid), 8'(m_valid[0]));
            check("rnd lo pending", bus_lo.pending, m_pend[0]);
            check("rnd lo overflow", 8'(bus_lo.overflow), 8'(m_ovf[0]));
            check("rnd hi code", 8'(bus_hi.code), 8'(m_code[1]));
            check("rnd hi valid", 8'(bus_hi.valid), 8'(m_valid[1]));
            check("rnd hi pending", bus_hi.pending, m_pend[1]);
            check("rnd hi overflow", 8'(bus_hi.overflow), 8'(m_ovf[1]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_encoder.md
# irq_encoder

Registered 8-to-3 priority encoder with a valid/ack handshake. It sits on the opposite side of the 3-to-8 select decoder. It collects up to eight request lines, latches their rising edges into a sticky pending register, and presents the index of the highest-priority unmasked pending source as a 3-bit code. The code is held until the consumer acknowledges it, and the decoder can then regenerate the one-hot select from that code.

## Interface
- LOW_FIRST, 1: 1 = index 0 is highest priority; 0 = index 7 is highest priority.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request lines, level inputs; a 0->1 transition between consecutive edges is one request.
- mask  input  8  1 = source ineligible for presentation. It still latches into pending.
- ack  input  1  consumer accepts the presented code; honoured only while valid=1.
- clr_ovf  input  1  synchronous clear of overflow.
- code  output  3  encoded index of the presented source.
- valid  output  1  code is meaningful and stable.
- pending  output  8  sticky pending register.
- overflow  output  1  sticky: a rising edge arrived on a bit already pending.

## Operation
- Edge detect: req_d <= req each edge; rise = req & ~req_d.
- Pending update, per bit each edge: pending_next = (pending & ~clr) | rise.
  - clr is one-hot on code when ack && valid, else 0.
  - A rise and a clear on the same bit in the same cycle: the rise wins and the bit stays set.
- overflow <= 1 when (rise & pending & ~clr) != 0.
  - clr_ovf clears it.
  - If clr_ovf and a new overflow event occur in the same cycle, the set wins.
- eligible = pending & ~mask. The winner is the lowest set index (LOW_FIRST=1) or the highest set index (LOW_FIRST=0).
- FSM, two states:
  - IDLE (valid=0): if eligible != 0, load code <= winner, set valid <= 1, go to PRESENT. Otherwise stay; code holds its last value.
  - PRESENT (valid=1): code and valid are frozen.
    - Changes to mask, new rises and higher-priority arrivals do not retract or change the presentation.
    - On ack: clear pending[code], set valid <= 0, go to IDLE.
- ack while in IDLE is ignored and has no effect on pending.
- Masking a source while it is pending does not clear it. Unmasking it later makes it eligible again.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, code=3'b000, valid=0, pending=8'h00, overflow=0, req_d=8'h00.
  - A req bit that is high when reset is released counts as a rise at the first edge.
- Latency:
  - req bit i rises before edge N, so pending[i]=1 after edge N.
  - If state is IDLE and i is the winner, valid=1 and code=i after edge N+1.
- Ack at edge M: valid=0 and pending[code]=0 after edge M. The earliest next valid is after edge M+1, so there is a minimum one-cycle gap.
- Sustained throughput: one code per 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-presentation: the presentation is dropped and all pending requests are lost.

## Test plan
- Reset, then pulse req=8'h08 for 1 cycle:
  - pending=8'h08 after edge 1.
  - valid=1 and code=3 after edge 2.
  - Hold 5 cycles without ack: code stays 3.
  - Then ack: valid=0 and pending=8'h00.
- req=8'h81 rises together, LOW_FIRST=1:
  - code=0 is presented first.
  - After ack, the gap cycle has valid=0.
  - Then code=7; after ack, pending=8'h00.
- mask=8'h01, req=8'h05 rises:
  - code=2 is presented; pending stays 8'h01 after its ack.
  - Then set mask=8'h00: code=0 is presented 1 cycle later.
- While code=2 is presented, req[0] rises: code stays 2 and pending becomes 8'h05. After ack, code=0.
- Overflow:
  - req[4] pulses, drops, then pulses again before ack: overflow=1 and pending[4] stays 1.
  - A single ack clears pending[4].
  - clr_ovf for 1 cycle: overflow=0.
- Edge cases:
  - ack in the same cycle that req[code] rises again: valid=0 but pending[code] stays 1, and the same code is re-presented 1 cycle later.
  - ack with valid=0: no state change.
  - rst_n pulsed low mid-PRESENT: all outputs return to reset values immediately.
